// File: rtl/amm_rr_arbiter_pkg.sv
// Shared types and helpers for the Avalon MM round-robin arbiter.
package amm_arb_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Index width needed to address n requesters (at least 1 bit).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < n) r = r + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/amm_rr_arbiter_if.sv
// Requester-side and bridge-side Avalon MM bundle of the arbiter.
interface amm_rr_arbiter_if #(
   parameter int P_ASIZE  = 32,
   parameter int P_DBYTES = 4,
   parameter int P_NREQ   = 4
);
   logic [P_NREQ*P_ASIZE-1:0]    s_address;
   logic [P_NREQ*P_DBYTES*8-1:0] s_writedata;
   logic [P_NREQ*P_DBYTES-1:0]   s_byteenable;
   logic [P_NREQ-1:0]            s_write;
   logic [P_NREQ-1:0]            s_read;
   logic [P_DBYTES*8-1:0]        s_readdata;
   logic [P_NREQ-1:0]            s_waitrequest;
   logic [P_ASIZE-1:0]           m_address;
   logic [P_DBYTES*8-1:0]        m_writedata;
   logic [P_DBYTES-1:0]          m_byteenable;
   logic                         m_write;
   logic                         m_read;
   logic [P_DBYTES*8-1:0]        m_readdata;
   logic                         m_waitrequest;
   logic [P_NREQ-1:0]            grant;

   // Arbiter view.
   modport slave (
      input  s_address, s_writedata, s_byteenable, s_write, s_read,
      input  m_readdata, m_waitrequest,
      output s_readdata, s_waitrequest,
      output m_address, m_writedata, m_byteenable, m_write, m_read, grant
   );

   // Environment view: requesters plus the bridge.
   modport master (
      output s_address, s_writedata, s_byteenable, s_write, s_read,
      output m_readdata, m_waitrequest,
      input  s_readdata, s_waitrequest,
      input  m_address, m_writedata, m_byteenable, m_write, m_read, grant
   );
endinterface

// File: rtl/amm_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after index last, wrapping.
module rr_pick #(
   parameter int P_NREQ = 4,
   parameter int IW     = 2
) (
   input  logic [P_NREQ-1:0] req,
   input  logic [IW-1:0]     last,
   output logic [P_NREQ-1:0] pick,
   output logic              valid
);
   logic [P_NREQ-1:0] upper_mask;
   logic [P_NREQ-1:0] upper_req;
   logic [P_NREQ-1:0] src;

   generate
      for (genvar gi = 0; gi < P_NREQ; gi++) begin : g_mask
         assign upper_mask[gi] = (IW'(gi) > last);
      end
   endgenerate

   // Prefer requesters above last; otherwise wrap to the lowest one.
   assign upper_req = req & upper_mask;
   assign src       = (|upper_req) ? upper_req : req;
   assign pick      = src & (~src + P_NREQ'(1));
   assign valid     = |req;
endmodule

// File: rtl/amm_rr_arbiter.sv
// Round-robin arbiter funnelling P_NREQ Avalon MM requesters onto one master port.
module amm_rr_arbiter
   import amm_arb_pkg::*;
#(
   parameter int P_ASIZE  = 32,
   parameter int P_DBYTES = 4,
   parameter int P_NREQ   = 4
) (
   input logic              clk,
   input logic              reset,
   amm_rr_arbiter_if.slave  bus
);
   localparam int IW = clog2(P_NREQ);

   state_t              state_q, state_d;
   logic [P_NREQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]       gidx_q, gidx_d;
   logic [IW-1:0]       last_q, last_d;
   logic [P_NREQ-1:0]   req;
   logic [P_NREQ-1:0]   pick;
   logic                pick_valid;
   logic [IW-1:0]       pick_idx;
   logic                busy;
   logic                wr_g;
   logic                rd_g;
   logic [P_NREQ-1:0]   wait_vec;

   assign req = bus.s_read | bus.s_write;

   rr_pick #(.P_NREQ(P_NREQ), .IW(IW)) u_pick (
      .req   (req),
      .last  (last_q),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < P_NREQ; i++) begin
         if (pick[i]) pick_idx = pick_idx | IW'(i);
      end
   end

   assign busy = (state_q == S_BUSY);
   assign wr_g = bus.s_write[gidx_q];
   assign rd_g = bus.s_read[gidx_q];

   // Write wins when a requester raises both strobes.
   assign bus.m_write      = busy & wr_g;
   assign bus.m_read       = busy & rd_g & ~wr_g;
   assign bus.m_address    = busy ? bus.s_address[gidx_q*P_ASIZE +: P_ASIZE] : '0;
   assign bus.m_writedata  = busy ? bus.s_writedata[gidx_q*P_DBYTES*8 +: P_DBYTES*8] : '0;
   assign bus.m_byteenable = busy ? bus.s_byteenable[gidx_q*P_DBYTES +: P_DBYTES] : '0;
   assign bus.s_readdata   = bus.m_readdata;
   assign bus.grant        = grant_q;

   always_comb begin
      wait_vec = '1;
      if (busy) wait_vec[gidx_q] = bus.m_waitrequest;
   end
   assign bus.s_waitrequest = wait_vec;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               state_d = S_BUSY;
               grant_d = pick;
               gidx_d  = pick_idx;
            end
         end
         S_BUSY: begin
            // Completion or abandonment both hand priority past this requester.
            if (!(wr_g || rd_g) || !bus.m_waitrequest) begin
               state_d = S_IDLE;
               grant_d = '0;
               last_d  = gidx_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(P_NREQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end
endmodule

// File: tb/tb_amm_rr_arbiter.sv
// Directed self-checking bench for amm_rr_arbiter.
module tb_amm_rr_arbiter;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   amm_rr_arbiter_if #(.P_ASIZE(32), .P_DBYTES(4), .P_NREQ(4)) bus ();

   amm_rr_arbiter #(.P_ASIZE(32), .P_DBYTES(4), .P_NREQ(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.s_address     = {32'h0000_1030, 32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
      bus.s_writedata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      bus.s_byteenable  = 16'hFFFF;
      bus.s_write       = 4'b0000;
      bus.s_read        = 4'b0000;
      bus.m_readdata    = 32'h0;
      bus.m_waitrequest = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
      total++; if (bus.m_write !== 1'b0 || bus.m_read !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", bus.m_write, bus.m_read); end
      total++; if (bus.s_waitrequest !== 4'b1111) begin bad++; $display("FAIL reset_wait got=%b exp=1111", bus.s_waitrequest); end
      total++; if (bus.m_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.m_address); end
   endtask

   task automatic test_alternate();
      logic [3:0]  exp_g [4];
      logic [31:0] exp_a [4];
      exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      exp_a = '{32'h1000, 32'h1020, 32'h1000, 32'h1020};
      apply_reset();
      bus.s_write = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (bus.grant !== exp_g[k]) begin bad++; $display("FAIL alt_grant[%0d] got=%b exp=%b", k, bus.grant, exp_g[k]); end
         total++; if (bus.m_write !== 1'b1 || bus.m_address !== exp_a[k]) begin bad++; $display("FAIL alt_bus[%0d] got=%b/%h exp=1/%h", k, bus.m_write, bus.m_address, exp_a[k]); end
         total++; if (bus.s_waitrequest !== ~exp_g[k]) begin bad++; $display("FAIL alt_wait[%0d] got=%b exp=%b", k, bus.s_waitrequest, ~exp_g[k]); end
         tick();
         total++; if (bus.grant !== 4'b0000 || bus.m_write !== 1'b0) begin bad++; $display("FAIL alt_gap[%0d] got=%b/%b exp=0000/0", k, bus.grant, bus.m_write); end
      end
      bus.s_write = 4'b0000;
   endtask

   task automatic test_reads();
      int idx;
      apply_reset();
      bus.s_read = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         idx = k % 4;
         tick();
         bus.m_readdata = 32'hA5A5_0000 + 32'(idx);
         #1;
         total++; if (bus.grant !== 4'(1 << idx)) begin bad++; $display("FAIL rd_grant[%0d] got=%b exp=%b", k, bus.grant, 4'(1 << idx)); end
         total++; if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0) begin bad++; $display("FAIL rd_strobe[%0d] got=%b%b exp=10", k, bus.m_read, bus.m_write); end
         total++; if (bus.s_readdata !== 32'hA5A5_0000 + 32'(idx)) begin bad++; $display("FAIL rd_data[%0d] got=%h exp=%h", k, bus.s_readdata, 32'hA5A5_0000 + 32'(idx)); end
         tick();
         total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rd_gap[%0d] got=%b exp=0000", k, bus.grant); end
      end
      bus.s_read = 4'b0000;
   endtask

   task automatic test_wait_write();
      apply_reset();
      bus.s_address[2*32 +: 32]  = 32'h0000_0100;
      bus.s_writedata[2*32 +: 32] = 32'hDEAD_BEEF;
      bus.s_byteenable[2*4 +: 4] = 4'hF;
      bus.m_waitrequest = 1'b1;
      bus.s_write = 4'b0100;
      #1;
      total++; if (bus.s_waitrequest !== 4'b1111 || bus.m_write !== 1'b0) begin bad++; $display("FAIL ww_idle got=%b/%b exp=1111/0", bus.s_waitrequest, bus.m_write); end
      tick();
      for (int c = 0; c < 5; c++) begin
         total++; if (bus.m_write !== 1'b1 || bus.m_address !== 32'h100 || bus.m_writedata !== 32'hDEAD_BEEF || bus.m_byteenable !== 4'hF)
            begin bad++; $display("FAIL ww_hold[%0d] got=%b/%h/%h/%h exp=1/100/deadbeef/f", c, bus.m_write, bus.m_address, bus.m_writedata, bus.m_byteenable); end
         total++; if (bus.s_waitrequest !== 4'b1111) begin bad++; $display("FAIL ww_wait[%0d] got=%b exp=1111", c, bus.s_waitrequest); end
         tick();
      end
      bus.m_waitrequest = 1'b0;
      #1;
      total++; if (bus.s_waitrequest !== 4'b1011 || bus.m_write !== 1'b1) begin bad++; $display("FAIL ww_done got=%b/%b exp=1011/1", bus.s_waitrequest, bus.m_write); end
      tick();
      bus.s_write = 4'b0000;
      #1;
      total++; if (bus.grant !== 4'b0000 || bus.s_waitrequest !== 4'b1111) begin bad++; $display("FAIL ww_after got=%b/%b exp=0000/1111", bus.grant, bus.s_waitrequest); end
   endtask

   task automatic test_abandon();
      apply_reset();
      bus.m_waitrequest = 1'b1;
      bus.s_read = 4'b0110;
      tick();
      total++; if (bus.grant !== 4'b0010 || bus.m_read !== 1'b1) begin bad++; $display("FAIL ab_grant got=%b/%b exp=0010/1", bus.grant, bus.m_read); end
      bus.s_read = 4'b0100;
      #1;
      total++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin bad++; $display("FAIL ab_nopulse got=%b%b exp=00", bus.m_read, bus.m_write); end
      tick();
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL ab_clear got=%b exp=0000", bus.grant); end
      tick();
      total++; if (bus.grant !== 4'b0100 || bus.m_read !== 1'b1) begin bad++; $display("FAIL ab_next got=%b/%b exp=0100/1", bus.grant, bus.m_read); end
      bus.m_waitrequest = 1'b0;
      tick();
      bus.s_read = 4'b0000;
   endtask

   task automatic test_reset_busy();
      apply_reset();
      bus.s_write = 4'b0010;
      tick();
      bus.s_write = 4'b0000;
      tick();
      bus.m_waitrequest = 1'b1;
      bus.s_write = 4'b0100;
      tick();
      total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL rb_busy got=%b exp=0100", bus.grant); end
      reset = 1'b1;
      bus.s_write = 4'b0101;
      tick();
      total++; if (bus.grant !== 4'b0000 || bus.m_write !== 1'b0 || bus.s_waitrequest !== 4'b1111)
         begin bad++; $display("FAIL rb_abort got=%b/%b/%b exp=0000/0/1111", bus.grant, bus.m_write, bus.s_waitrequest); end
      reset = 1'b0;
      tick();
      total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL rb_first got=%b exp=0001", bus.grant); end
      bus.m_waitrequest = 1'b0;
      tick();
      bus.s_write = 4'b0000;
   endtask

   task automatic test_rw_both();
      apply_reset();
      bus.m_waitrequest = 1'b1;
      bus.s_read  = 4'b1000;
      bus.s_write = 4'b1000;
      tick();
      total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL rw_grant got=%b exp=1000", bus.grant); end
      total++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin bad++; $display("FAIL rw_strobe got=%b%b exp=10", bus.m_write, bus.m_read); end
      bus.m_waitrequest = 1'b0;
      tick();
      bus.s_read  = 4'b0000;
      bus.s_write = 4'b0000;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_alternate();
      test_reads();
      test_wait_write();
      test_abandon();
      test_reset_busy();
      test_rw_both();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
